// File: rtl/dbg_console_ctrl_pkg.sv
// Shared definitions for the Mock8080 front-panel debug console: FSM state
// encodings and the default debounce length.
package dbg_console_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_STEP    = 2'd1,
    ST_RUN     = 2'd2
  } console_state_t;

  // 4 ms of stable level at 50 MHz
  localparam int DEB_CYCLES_DEFAULT = 200000;

endpackage

// File: rtl/dbg_button_debounce.sv
// One front-panel button: 2-FF synchroniser, stability counter and a one-cycle
// press pulse. Optional hold-to-repeat is built only when AUTOREPEAT_EN is defined.
module dbg_button_debounce
  import dbg_console_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
`ifdef AUTOREPEAT_EN
  ,
  parameter bit REPEAT_EN  = 1'b0,
  parameter int REP_DELAY  = 25000000,
  parameter int REP_PERIOD = 5000000
`endif
) (
  input  logic clk_qzt,
  input  logic reset_n,
  input  logic btn_raw,
  output logic press
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync_a;
  logic             sync_b;
  logic             stable;
  logic             stable_q;
  logic [CNT_W-1:0] stab_cnt;
  logic             edge_pulse;
  logic             rep_fire;

  always_ff @(posedge clk_qzt or negedge reset_n) begin
    if (!reset_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= btn_raw;
      sync_b <= sync_a;
    end
  end

  // Any sample that agrees with the accepted level restarts the count, so only
  // DEB_CYCLES consecutive disagreeing samples move the accepted level.
  always_ff @(posedge clk_qzt or negedge reset_n) begin
    if (!reset_n) begin
      stable   <= 1'b0;
      stab_cnt <= '0;
    end else if (sync_b == stable) begin
      stab_cnt <= '0;
    end else if (stab_cnt == CNT_LAST) begin
      stable   <= sync_b;
      stab_cnt <= '0;
    end else begin
      stab_cnt <= stab_cnt + 1'b1;
    end
  end

  assign edge_pulse = stable & ~stable_q;

`ifdef AUTOREPEAT_EN
  logic [31:0] rep_cnt;
  logic        rep_armed;

  assign rep_fire = REPEAT_EN && stable &&
                    (rep_cnt == (rep_armed ? 32'(REP_PERIOD - 1) : 32'(REP_DELAY - 1)));

  always_ff @(posedge clk_qzt or negedge reset_n) begin
    if (!reset_n) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
    end else if (!REPEAT_EN || !stable) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
    end else if (rep_fire) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b1;
    end else begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge clk_qzt or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= 1'b0;
      press    <= 1'b0;
    end else begin
      stable_q <= stable;
      press    <= edge_pulse | rep_fire;
    end
  end

endmodule

// File: rtl/dbg_console_ctrl.sv
// Mock8080 front-panel debug controller: debounced buttons, wrapping selector and
// address probes, and CPU clock-enable in STOPPED/STEP/RUN. Define AUTOREPEAT_EN for hold-to-repeat on up/down.
module dbg_console_ctrl
  import dbg_console_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
  parameter int SEL_W      = 4,
  parameter int SEL_LIMIT  = 12,
  parameter int ADDR_W     = 8,
  parameter int RUN_DIV    = 25000
`ifdef AUTOREPEAT_EN
  ,
  parameter int REP_DELAY  = 25000000,
  parameter int REP_PERIOD = 5000000
`endif
) (
  input  logic              clk_qzt,
  input  logic              reset_n,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_step,
  input  logic              btn_run,
  input  logic              mode_ram,
  input  logic              cpu_halt,
  output logic [SEL_W-1:0]  sel_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic              cpu_clk_en,
  output logic              running
);

  localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
  localparam logic [SEL_W-1:0] SEL_MAX  = SEL_W'(SEL_LIMIT);

  logic up_pulse;
  logic down_pulse;
  logic step_pulse;
  logic run_pulse;

  console_state_t   state;
  console_state_t   state_next;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_next;
  logic             clk_en_next;

`ifdef AUTOREPEAT_EN
  dbg_button_debounce #(
    .DEB_CYCLES(DEB_CYCLES), .REPEAT_EN(1'b1), .REP_DELAY(REP_DELAY), .REP_PERIOD(REP_PERIOD)
  ) u_deb_up (.clk_qzt(clk_qzt), .reset_n(reset_n), .btn_raw(btn_up), .press(up_pulse));

  dbg_button_debounce #(
    .DEB_CYCLES(DEB_CYCLES), .REPEAT_EN(1'b1), .REP_DELAY(REP_DELAY), .REP_PERIOD(REP_PERIOD)
  ) u_deb_down (.clk_qzt(clk_qzt), .reset_n(reset_n), .btn_raw(btn_down), .press(down_pulse));
`else
  dbg_button_debounce #(.DEB_CYCLES(DEB_CYCLES))
    u_deb_up (.clk_qzt(clk_qzt), .reset_n(reset_n), .btn_raw(btn_up), .press(up_pulse));

  dbg_button_debounce #(.DEB_CYCLES(DEB_CYCLES))
    u_deb_down (.clk_qzt(clk_qzt), .reset_n(reset_n), .btn_raw(btn_down), .press(down_pulse));
`endif

  dbg_button_debounce #(.DEB_CYCLES(DEB_CYCLES))
    u_deb_step (.clk_qzt(clk_qzt), .reset_n(reset_n), .btn_raw(btn_step), .press(step_pulse));

  dbg_button_debounce #(.DEB_CYCLES(DEB_CYCLES))
    u_deb_run (.clk_qzt(clk_qzt), .reset_n(reset_n), .btn_raw(btn_run), .press(run_pulse));

  // Opposing pulses in the same cycle cancel; mode_ram picks the target.
  always_ff @(posedge clk_qzt or negedge reset_n) begin
    if (!reset_n) begin
      sel_out  <= '0;
      addr_out <= '0;
    end else if (up_pulse ^ down_pulse) begin
      if (mode_ram) begin
        addr_out <= up_pulse ? addr_out + 1'b1 : addr_out - 1'b1;
      end else if (up_pulse) begin
        sel_out <= (sel_out == SEL_MAX) ? '0 : sel_out + 1'b1;
      end else begin
        sel_out <= (sel_out == '0) ? SEL_MAX : sel_out - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_qzt or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_STOPPED;
      div_cnt    <= '0;
      cpu_clk_en <= 1'b0;
      running    <= 1'b0;
    end else begin
      state      <= state_next;
      div_cnt    <= div_next;
      cpu_clk_en <= clk_en_next;
      running    <= (state_next == ST_RUN);
    end
  end

  // The strobe is computed one cycle early so the registered cpu_clk_en lines
  // up with the cycle in which the divider holds its last count.
  always_comb begin
    state_next  = state;
    div_next    = div_cnt;
    clk_en_next = 1'b0;
    unique case (state)
      ST_STOPPED: begin
        if (run_pulse && !cpu_halt) begin
          state_next = ST_RUN;
          div_next   = '0;
        end else if (step_pulse) begin
          state_next  = ST_STEP;
          clk_en_next = 1'b1;
        end
      end
      ST_STEP: begin
        state_next = ST_STOPPED;
      end
      ST_RUN: begin
        if (run_pulse || cpu_halt) begin
          state_next = ST_STOPPED;
        end else begin
          div_next    = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
          clk_en_next = (div_next == DIV_LAST);
        end
      end
      default: begin
        state_next = ST_STOPPED;
      end
    endcase
  end

endmodule
